instrmem_responder: RTL

//  Instruction-memory side of the fetch interface: services fetch read requests (pc, instrmem_rd)
//  and returns the 16-bit LC3 instruction after a programmable latency.

---
 rtl/lc3_pkg.sv | 16 +
 rtl/instrmem_responder_if.sv | 28 ++
 rtl/instrmem_array.sv | 28 ++
 rtl/instrmem_responder.sv | 105 ++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 fetch-side types and constants: program origin, NOP encoding,
// the instruction-memory responder state encoding and the 16-bit word type.
package lc3_pkg;

   localparam logic [15:0] LC3_INSTR_BASE = 16'h3000;
   localparam logic [15:0] LC3_NOP        = 16'h0000;

   typedef enum logic [1:0] {
      IM_IDLE,
      IM_WAIT,
      IM_RESP
   } im_state_t;

   typedef logic [15:0] lc3_word_t;

endpackage

// File: rtl/instrmem_responder_if.sv
// Fetch/preload bus between the fetch controller (master) and the
// instruction-memory responder (slave).
interface instrmem_responder_if #(
   parameter int ADDR_W = 8
);
   import lc3_pkg::*;

   lc3_word_t          pc;
   logic               instrmem_rd;
   logic               instrmem_busy;
   lc3_word_t          dout;
   logic               instr_valid;
   logic               addr_err;
   logic               ld_en;
   logic [ADDR_W-1:0]  ld_addr;
   lc3_word_t          ld_data;

   modport master (
      output pc, instrmem_rd, ld_en, ld_addr, ld_data,
      input  instrmem_busy, dout, instr_valid, addr_err
   );

   modport slave (
      input  pc, instrmem_rd, ld_en, ld_addr, ld_data,
      output instrmem_busy, dout, instr_valid, addr_err
   );

endinterface

// File: rtl/instrmem_array.sv
// Instruction storage: synchronous write port for preload, combinational read
// so a same-edge load and fetch of one word returns the old contents.
module instrmem_array
   import lc3_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  lc3_word_t         wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output lc3_word_t         rdata_o
);

   lc3_word_t mem_q [2**ADDR_W];

   // NOTE: the array deliberately has no reset; program contents survive a
   // reset and a reset loop over every word would not map onto RAM.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instrmem_responder.sv
// Instruction-memory responder: accepts fetch reads, returns the word after
// LATENCY cycles with a one-cycle instr_valid pulse, flags out-of-range pc.
module instrmem_responder
   import lc3_pkg::*;
#(
   parameter int              ADDR_W    = 8,
   parameter int              LATENCY   = 2,
   parameter logic [15:0]     BASE_ADDR = LC3_INSTR_BASE
) (
   input  logic               clock,
   input  logic               reset,
   instrmem_responder_if.slave bus
);

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   im_state_t  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   lc3_word_t  resp_q, resp_d;
   logic       resp_err_q, resp_err_d;
   lc3_word_t  dout_q;
   logic       valid_q;
   logic       busy_q;
   logic       err_q;

   lc3_word_t  offset;
   logic       in_range;
   logic       accept;
   lc3_word_t  rd_word;

   // pc below BASE_ADDR wraps to a large offset and lands out of range
   assign offset   = bus.pc - BASE_ADDR;
   assign in_range = ((offset >> ADDR_W) == 16'd0);
   assign accept   = ((state_q == IM_IDLE) || (state_q == IM_RESP))
                     && (bus.instrmem_rd === 1'b1);

   instrmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clock   (clock),
      .we_i    (bus.ld_en),
      .waddr_i (bus.ld_addr),
      .wdata_i (bus.ld_data),
      .raddr_i (offset[ADDR_W-1:0]),
      .rdata_o (rd_word)
   );

   // NOTE: every next-state variable gets its hold value first, so no path
   // through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      resp_d     = resp_q;
      resp_err_d = resp_err_q;

      case (state_q)
         IM_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IM_RESP;
            end
         end
         default: state_d = IM_IDLE;
      endcase

      if (accept) begin
         resp_d     = in_range ? rd_word : LC3_NOP;
         resp_err_d = !in_range;
         cnt_d      = LAT_M1;
         state_d    = (LATENCY == 1) ? IM_RESP : IM_WAIT;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IM_IDLE;
         cnt_q      <= 4'd0;
         resp_q     <= LC3_NOP;
         resp_err_q <= 1'b0;
         dout_q     <= LC3_NOP;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         resp_q     <= resp_d;
         resp_err_q <= resp_err_d;
         busy_q     <= (state_d == IM_WAIT);
         valid_q    <= (state_q == IM_RESP);
         err_q      <= (state_q == IM_RESP) && resp_err_q;
         if (state_q == IM_RESP) begin
            dout_q <= resp_q;
         end
      end
   end

   assign bus.instrmem_busy = busy_q;
   assign bus.dout          = dout_q;
   assign bus.instr_valid   = valid_q;
   assign bus.addr_err      = err_q;

endmodule
